// File: rtl/nes_clock_pkg.sv
// Shared types and default constants for the NES clock/reset sequencer.
package nes_clock_pkg;

  typedef enum logic [1:0] {
    RESET,
    WAIT_LOCK,
    STABILIZE,
    RUN
  } clk_state_e;

  localparam int unsigned NES_CPU_DIV       = 12;
  localparam int unsigned NES_PPU_DIV       = 4;
  localparam int unsigned NES_STABLE_CYCLES = 1024;
  localparam int unsigned NES_SYNC_STAGES   = 2;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nes_clock_enable_gen_sync.sv
// N-stage flip-flop synchronizer for a single asynchronous bit, reset to 0.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/nes_clock_enable_gen.sv
// Holds the system in reset until the PLL lock is stable, then generates the
// phase-aligned CPU and PPU clock enables from the master clock.
module nes_clock_enable_gen
  import nes_clock_pkg::*;
#(
  parameter int unsigned CPU_DIV       = NES_CPU_DIV,
  parameter int unsigned PPU_DIV       = NES_PPU_DIV,
  parameter int unsigned STABLE_CYCLES = NES_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = NES_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic pause,
  output logic sys_rst_n,
  output logic ce_cpu,
  output logic ce_cpu_half,
  output logic ce_ppu,
  output logic running
);

  localparam int unsigned CPU_W  = cnt_width(CPU_DIV);
  localparam int unsigned PPU_W  = cnt_width(PPU_DIV);
  localparam int unsigned STAB_W = cnt_width(STABLE_CYCLES);

  localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CPU_DIV - 1);
  localparam logic [CPU_W-1:0]  CPU_MID   = CPU_W'(CPU_DIV / 2 - 1);
  localparam logic [PPU_W-1:0]  PPU_LAST  = PPU_W'(PPU_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic              lock_s;
  clk_state_e        state, state_next;
  logic [STAB_W-1:0] stab_cnt, stab_next;
  logic [CPU_W-1:0]  cpu_cnt, cpu_next;
  logic [PPU_W-1:0]  ppu_cnt, ppu_next;
  logic              advance;
  logic              run_q;
  logic              ce_cpu_next, ce_cpu_half_next, ce_ppu_next;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next state, counters and pulses. Pulses fire on the cycle a counter
  // steps into its terminal value, so a held (paused) count never repeats one.
  always_comb begin
    state_next       = state;
    stab_next        = '0;
    cpu_next         = '0;
    ppu_next         = '0;
    advance          = 1'b0;
    ce_cpu_next      = 1'b0;
    ce_cpu_half_next = 1'b0;
    ce_ppu_next      = 1'b0;

    unique case (state)
      RESET: state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) state_next = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s)                    state_next = WAIT_LOCK;
        else if (stab_cnt == STAB_LAST) state_next = RUN;
        else                            stab_next  = stab_cnt + STAB_W'(1);
      end
      RUN: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else begin
          cpu_next = cpu_cnt;
          ppu_next = ppu_cnt;
          if (!pause) begin
            advance  = 1'b1;
            cpu_next = (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + CPU_W'(1);
            ppu_next = (ppu_cnt == PPU_LAST) ? '0 : ppu_cnt + PPU_W'(1);
          end
        end
      end
      default: state_next = RESET;
    endcase

    ce_cpu_next      = advance && (cpu_next == CPU_LAST);
    ce_cpu_half_next = advance && (cpu_next == CPU_MID);
    ce_ppu_next      = advance && (ppu_next == PPU_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET;
      stab_cnt    <= '0;
      cpu_cnt     <= '0;
      ppu_cnt     <= '0;
      run_q       <= 1'b0;
      ce_cpu      <= 1'b0;
      ce_cpu_half <= 1'b0;
      ce_ppu      <= 1'b0;
    end else begin
      state       <= state_next;
      stab_cnt    <= stab_next;
      cpu_cnt     <= cpu_next;
      ppu_cnt     <= ppu_next;
      run_q       <= (state_next == RUN);
      ce_cpu      <= ce_cpu_next;
      ce_cpu_half <= ce_cpu_half_next;
      ce_ppu      <= ce_ppu_next;
    end
  end

  assign sys_rst_n = run_q;
  assign running   = run_q;

endmodule

// File: tb/tb_nes_clock_enable_gen.sv
// Directed plus randomized bench for nes_clock_enable_gen against a
// cycle-level behavioural model of lock stability and enable cadence.
module tb_nes_clock_enable_gen;

  localparam int unsigned CPU_DIV = 12;
  localparam int unsigned PPU_DIV = 4;
  localparam int unsigned STABLE  = 16;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned REL_LAT = SYNC + 1 + STABLE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic pause = 1'b0;
  logic sys_rst_n, ce_cpu, ce_cpu_half, ce_ppu, running;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: lock_s is pll_locked delayed SYNC edges; RUN holds once lock_s has
  // been high for STABLE+1 consecutive cycles; m_k counts unpaused RUN steps.
  bit          m_sync[$];
  int unsigned m_hi;
  bit          m_run;
  int unsigned m_k;
  bit          m_cpu, m_half, m_ppu;

  nes_clock_enable_gen #(
    .CPU_DIV       (CPU_DIV),
    .PPU_DIV       (PPU_DIV),
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pause       (pause),
    .sys_rst_n   (sys_rst_n),
    .ce_cpu      (ce_cpu),
    .ce_cpu_half (ce_cpu_half),
    .ce_ppu      (ce_ppu),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    m_sync = {};
    for (int i = 0; i < int'(SYNC); i++) m_sync.push_back(1'b0);
    m_hi   = 0;
    m_run  = 1'b0;
    m_k    = 0;
    m_cpu  = 1'b0;
    m_half = 1'b0;
    m_ppu  = 1'b0;
  endtask

  task automatic model_edge();
    bit run_new, adv, ls;
    if (!rst_n) begin
      model_reset();
      return;
    end
    run_new = (m_hi >= STABLE + 1);
    adv     = run_new && m_run && !pause;
    if (!run_new) m_k = 0;
    else if (adv) m_k++;
    m_cpu  = adv && (m_k % CPU_DIV == CPU_DIV - 1);
    m_half = adv && (m_k % CPU_DIV == CPU_DIV / 2 - 1);
    m_ppu  = adv && (m_k % PPU_DIV == PPU_DIV - 1);
    m_sync.push_back(pll_locked);
    void'(m_sync.pop_front());
    ls    = m_sync[0];
    m_hi  = ls ? m_hi + 1 : 0;
    m_run = run_new;
  endtask

  task automatic check_outputs();
    check("sys_rst_n",   32'(sys_rst_n),   32'(m_run));
    check("running",     32'(running),     32'(m_run));
    check("ce_cpu",      32'(ce_cpu),      32'(m_cpu));
    check("ce_cpu_half", 32'(ce_cpu_half), 32'(m_half));
    check("ce_ppu",      32'(ce_ppu),      32'(m_ppu));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic wait_rise(output int n, input int limit);
    n = 0;
    do begin
      step();
      n++;
    end while (sys_rst_n !== 1'b1 && n < limit);
  endtask

  task automatic wait_cpu(output int n, input int limit);
    n = 0;
    do begin
      step();
      n++;
    end while (ce_cpu !== 1'b1 && n < limit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n, n_cpu, n_ppu, n_half, last_half, low_left;
    model_reset();

    // Reset held for 5 cycles, lock raised at cycle 10.
    repeat (5) step();
    rst_n = 1'b1;
    while (cyc < 10) step();
    pll_locked = 1'b1;
    wait_rise(n, 60);
    check("release_latency", 32'(n), REL_LAT);
    wait_cpu(n, 40);
    check("first_ce_cpu", 32'(n), 32'd11);

    // Lock loss at RUN index 50 for 3 cycles.
    repeat (39) step();
    pll_locked = 1'b0;
    repeat (2) step();
    check("lockloss_still_run", 32'(sys_rst_n), 32'd1);
    step();
    check("lockloss_rst", 32'(sys_rst_n), 32'd0);
    check("lockloss_ce", 32'({ce_cpu, ce_cpu_half, ce_ppu}), 32'd0);
    pll_locked = 1'b1;
    wait_rise(n, 60);
    check("relock_latency", 32'(n), REL_LAT);
    wait_cpu(n, 40);
    check("relock_first_cpu", 32'(n), 32'd11);

    // Steady-state cadence over 1200 cycles.
    n_cpu = 0; n_ppu = 0; n_half = 0; last_half = -100;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (ce_ppu === 1'b1) n_ppu++;
      if (ce_cpu_half === 1'b1) begin
        n_half++;
        last_half = cyc;
      end
      if (ce_cpu === 1'b1) begin
        n_cpu++;
        check("cpu_on_ppu", 32'(ce_ppu), 32'd1);
        check("half_to_cpu", 32'(cyc - last_half), 32'd6);
      end
    end
    check("cadence_cpu", 32'(n_cpu), 32'd100);
    check("cadence_ppu", 32'(n_ppu), 32'd300);
    check("cadence_half", 32'(n_half), 32'd100);

    // Random pause traffic in RUN.
    for (int i = 0; i < 300; i++) begin
      pause = ($urandom_range(0, 3) == 0);
      step();
    end
    pause = 1'b0;

    // Pause for 7 cycles starting at cpu_cnt = 9.
    wait_cpu(n, 40);
    check("pause_sync", 32'(ce_cpu), 32'd1);
    repeat (10) step();
    pause = 1'b1;
    repeat (7) begin
      step();
      check("paused_quiet", 32'({ce_cpu, ce_cpu_half, ce_ppu}), 32'd0);
    end
    pause = 1'b0;
    step();
    check("resume_early", 32'(ce_cpu), 32'd0);
    step();
    check("resume_cpu", 32'(ce_cpu), 32'd1);

    // Random lock drops and pauses.
    low_left = 0;
    for (int i = 0; i < 600; i++) begin
      if (low_left > 0) low_left--;
      else if ($urandom_range(0, 63) == 0) low_left = int'($urandom_range(1, 4));
      pll_locked = (low_left == 0);
      pause      = ($urandom_range(0, 4) == 0);
      step();
    end
    pause = 1'b0;

    // One-cycle lock glitch in the middle of STABILIZE.
    pll_locked = 1'b0;
    repeat (5) step();
    check("glitch_idle", 32'(sys_rst_n), 32'd0);
    pll_locked = 1'b1;
    repeat (11) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_rise(n, 60);
    check("glitch_release", 32'(n), REL_LAT);

    // Asynchronous reset between clock edges while in RUN.
    repeat (12) step();
    check("pre_reset_run", 32'(sys_rst_n), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_sys_rst_n",   32'(sys_rst_n),   32'd0);
    check("async_running",     32'(running),     32'd0);
    check("async_ce_cpu",      32'(ce_cpu),      32'd0);
    check("async_ce_cpu_half", 32'(ce_cpu_half), 32'd0);
    check("async_ce_ppu",      32'(ce_ppu),      32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_rise(n, 60);
    check("post_reset_release", 32'(n), REL_LAT);
    wait_cpu(n, 40);
    check("post_reset_first_cpu", 32'(n), 32'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
